// File: rtl/seg_scan_4digit.sv
// ---------------------------------------------------------------------------
// seg_scan_4digit
//   Four-digit multiplexed seven-segment driver (common anode, active-low).
//   A slow square wave (scanClk) from the scan-rate divider advances the lit
//   digit by one on every rising edge. After each advance all anodes are held
//   off for BLANK_CYCLES clocks to suppress ghosting. The displayed frame is
//   captured only when the scan wraps from digit 3 back to digit 0, so a
//   half-updated value is never shown.
//
// Parameters
//   BLANK_CYCLES : clkIn cycles of all-off after each digit advance (0 = none)
//   DIGITS       : digit count; must be 4 (checked at elaboration)
//
// Ports
//   clkIn   in   1   system clock
//   rstN    in   1   asynchronous active-low reset
//   scanClk in   1   digit-advance square wave (untrusted, synchronized here)
//   dataIn  in  16   four nibbles, [3:0] = rightmost digit (digit 0)
//   dpIn    in   4   decimal points, bit i = digit i, 1 = lit
//   anode   out  4   digit enables, active-low, bit i = digit i
//   seg     out  7   segments {g,f,e,d,c,b,a}, active-low
//   dp      out  1   decimal point, active-low
//
// Build option
//   SEG_SCAN_LZB_EN : when defined, digits 3..1 are blanked (segments off,
//                     dp still honoured) while they and every more
//                     significant nibble are zero. Digit 0 is never blanked.
// ---------------------------------------------------------------------------
module seg_scan_4digit #(
  parameter int BLANK_CYCLES = 64,
  parameter int DIGITS       = 4
) (
  input  logic        clkIn,
  input  logic        rstN,
  input  logic        scanClk,
  input  logic [15:0] dataIn,
  input  logic [3:0]  dpIn,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam logic [15:0] C_BLANK_INIT = 16'(BLANK_CYCLES);

  if (DIGITS != 4) begin : g_digits_check
    $error("seg_scan_4digit supports DIGITS == 4 only");
  end

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t      r_state, w_state_next;
  logic [15:0] r_cnt, w_cnt_next;
  logic [1:0]  r_idx, w_idx_next;
  logic [15:0] r_frame, w_frame_next;
  logic [3:0]  r_frame_dp, w_frame_dp_next;

  logic r_sync_ff1, r_sync_ff2, r_scan_d1, r_scan_d2, r_edge_pulse;

  logic [3:0] w_nib;
  logic [6:0] w_seg_dec;
  logic [3:0] w_anode_next;
  logic [6:0] w_seg_next;
  logic       w_dp_next;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Two-FF synchronizer followed by a delayed, registered rising-edge
  // detector: the pulse is high for one cycle, three clocks after the rise
  // is first sampled by r_sync_ff1.
  always_ff @(posedge clkIn or negedge rstN) begin
    if (!rstN) begin
      r_sync_ff1   <= 1'b0;
      r_sync_ff2   <= 1'b0;
      r_scan_d1    <= 1'b0;
      r_scan_d2    <= 1'b0;
      r_edge_pulse <= 1'b0;
    end else begin
      r_sync_ff1   <= scanClk;
      r_sync_ff2   <= r_sync_ff1;
      r_scan_d1    <= r_sync_ff2;
      r_scan_d2    <= r_scan_d1;
      r_edge_pulse <= r_scan_d1 & ~r_scan_d2;
    end
  end

  // Next-state logic. An edge always wins over the blank countdown, so a
  // second edge during BLANK advances once more and restarts the blank.
  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_idx_next      = r_idx;
    w_frame_next    = r_frame;
    w_frame_dp_next = r_frame_dp;
    if (r_edge_pulse) begin
      w_idx_next = r_idx + 2'd1;
      if (r_idx == 2'd3) begin
        w_frame_next    = dataIn;
        w_frame_dp_next = dpIn;
      end
      if (C_BLANK_INIT == 16'd0) begin
        w_state_next = ST_SHOW;
        w_cnt_next   = 16'd0;
      end else begin
        w_state_next = ST_BLANK;
        w_cnt_next   = C_BLANK_INIT;
      end
    end else if (r_state == ST_BLANK) begin
      // Leave BLANK on the cycle the counter reaches zero; a zero count
      // (BLANK_CYCLES = 0 out of reset) leaves immediately.
      if (r_cnt <= 16'd1) begin
        w_cnt_next   = 16'd0;
        w_state_next = ST_SHOW;
      end else begin
        w_cnt_next = r_cnt - 16'd1;
      end
    end
  end

  // Outputs are decoded from next-state values and registered, so anode,
  // seg and dp all switch on the same edge as the state they belong to.
  assign w_nib = w_frame_next[{w_idx_next, 2'b00} +: 4];

`ifdef SEG_SCAN_LZB_EN
  logic [3:0] w_upper_zero;
  assign w_upper_zero[0] = 1'b0;
  for (genvar gi = 1; gi < 4; gi++) begin : g_lzb
    assign w_upper_zero[gi] = (w_frame_next[15:4*gi] == '0);
  end
  assign w_seg_dec = w_upper_zero[w_idx_next] ? 7'b1111111 : f_decode(w_nib);
`else
  assign w_seg_dec = f_decode(w_nib);
`endif

  always_comb begin
    w_anode_next = 4'b1111;
    w_seg_next   = 7'b1111111;
    w_dp_next    = 1'b1;
    if (w_state_next == ST_SHOW) begin
      w_anode_next = ~(4'b0001 << w_idx_next);
      w_seg_next   = w_seg_dec;
      w_dp_next    = ~w_frame_dp_next[w_idx_next];
    end
  end

  always_ff @(posedge clkIn or negedge rstN) begin
    if (!rstN) begin
      r_state    <= ST_BLANK;
      r_cnt      <= C_BLANK_INIT;
      r_idx      <= 2'd0;
      r_frame    <= 16'h0000;
      r_frame_dp <= 4'b0000;
      anode      <= 4'b1111;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_idx      <= w_idx_next;
      r_frame    <= w_frame_next;
      r_frame_dp <= w_frame_dp_next;
      anode      <= w_anode_next;
      seg        <= w_seg_next;
      dp         <= w_dp_next;
    end
  end

endmodule
